line_fifo: RTL and testbench
============================

Name: line_fifo

Overview:
- Parametrised line-buffering byte FIFO between the pport receive and transmit interfaces.
- Stores received bytes and releases them to the transmitter only once they are "committed". A group is committed by:
  - a line terminator,
  - reaching a maximum line length,
  - an idle timeout, or
  - immediately, in pass-through mode.
- Successor to the fixed 256-entry/80-column line echo. Adds configurable depth, width, line length, terminators and timeout, uses the full buffer capacity, and reports status.

Parameters:
- DW, 8, data word width in bits.
- LGFLEN, 8, log2 of FIFO depth; depth = 2^LGFLEN words, all usable.
- MAXLINE, 80, uncommitted-word count that forces a commit; 1 to 2^LGFLEN.
- TERM_A, 8'h0a, first terminator value (zero-extended to DW).
- TERM_B, 8'h0d, second terminator value (zero-extended to DW).
- TIMEOUT, 0, idle clocks before uncommitted data is committed; 0 disables.
- TOW, 24, width of the timeout counter.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_line_mode  in  1  1 = line-buffered; 0 = pass-through (every stored word committed immediately).
- i_rx_stb  in  1  one-cycle strobe: i_rx_data valid.
- i_rx_data  in  DW  received word.
- o_tx_stb  out  1  transmit request; o_tx_data valid while high.
- o_tx_data  out  DW  word to transmit.
- i_tx_busy  in  1  transmitter busy; a word is accepted when o_tx_stb && !i_tx_busy.
- o_fill  out  LGFLEN+1  words currently stored.
- o_empty  out  1  o_fill == 0.
- o_full  out  1  o_fill == 2^LGFLEN.
- o_overflow  out  1  sticky: a received word was dropped.

Behaviour:
- Interface: one clock, i_clk; reset i_reset is synchronous and active-high.
- Reset: the first edge with i_reset high zeroes head, tail and commit pointers, the timeout counter, o_tx_stb, o_fill and o_overflow. o_empty=1, o_full=0, o_tx_data don't-care. Reset mid-transfer discards all contents with no further o_tx_stb.
- Pointers:
  - head, tail and commit are LGFLEN+1 bits; memory is indexed by the low LGFLEN bits.
  - fill = head - tail, modulo 2^(LGFLEN+1); wrap-around needs no special handling.
  - Invariant: tail <= commit <= head (modular).
- Write:
  - i_rx_stb && !full: store the word at head; head+1 on the next edge.
  - i_rx_stb && full: drop the word and set o_overflow.
  - A simultaneous accept by the transmitter does not free space for that same cycle's write.
- Commit, evaluated in priority order on each edge:
  1. i_line_mode=0: commit <= next head.
  2. Rx word equal to TERM_A or TERM_B and stored: commit <= head+1, so the terminator is included.
  3. Terminator dropped because the FIFO is full: commit <= head.
  4. (head - commit) >= MAXLINE: commit <= head.
  5. TIMEOUT != 0, counter == TIMEOUT and head != commit: commit <= head.
- Timeout counter:
  - Clears on i_rx_stb, on any commit, and when head == commit.
  - Otherwise increments, saturating at TIMEOUT.
- Transmit:
  - o_tx_stb rises on the edge after tail != commit is true, with o_tx_data = mem[tail] registered on the same edge.
  - While o_tx_stb && i_tx_busy, o_tx_stb and o_tx_data hold stable.
  - On accept: tail+1, and o_tx_stb is low for exactly the next cycle. It then reasserts with the new word if tail != commit still holds.
  - Maximum throughput is one word per two clocks.
  - Uncommitted words are never presented.
- Status: o_fill, o_empty and o_full are registered and reflect the pointers after each edge. o_overflow clears only on reset.

Test Plan:
- Line mode, DW=8, LGFLEN=4, MAXLINE=80 effective: rx "AB\n" (41,42,0a) -> no o_tx_stb until 0a stored; tx 41,42,0a in order, one stb-low cycle between accepts; o_empty=1 afterward.
- Length commit, MAXLINE=4, line mode: rx 6 non-terminators 30..35 -> 30..33 transmitted; 34,35 held with o_fill=2 and no o_tx_stb.
- Full/overflow, LGFLEN=4, i_tx_busy=1: rx 17 words with "\r" as word 17 -> o_full=1 after 16 stored; word 17 dropped, o_overflow=1; commit=head, so 16 words become eligible once busy drops.
- Timeout, TIMEOUT=10: rx 55 then idle -> o_tx_stb rises within 12 clocks of the rx strobe carrying 55; an rx at clock 9 restarts the count.
- Pass-through (i_line_mode=0) with i_tx_busy held 5 cycles: rx 61 -> o_tx_stb=1, o_tx_data=61 stable through busy; accepted on the first !busy cycle.
- Reset mid-drain: assert i_reset while o_tx_stb=1 with 3 words pending -> next cycle o_tx_stb=0, o_fill=0, o_overflow=0, no further transmits.

Source files
------------

// File: rtl/line_fifo.sv
// Line-buffering word FIFO between a receiver and a transmitter.
// Bytes become visible to the transmitter only after a group is committed.
module line_fifo #(
    parameter int unsigned DW      = 8,
    parameter int unsigned LGFLEN  = 8,
    parameter int unsigned MAXLINE = 80,
    parameter logic [7:0]  TERM_A  = 8'h0a,
    parameter logic [7:0]  TERM_B  = 8'h0d,
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned TOW     = 24
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_line_mode,
    input  logic              i_rx_stb,
    input  logic [DW-1:0]     i_rx_data,
    output logic              o_tx_stb,
    output logic [DW-1:0]     o_tx_data,
    input  logic              i_tx_busy,
    output logic [LGFLEN:0]   o_fill,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow
);

    localparam int unsigned     DEPTH      = 32'd1 << LGFLEN;
    localparam logic [LGFLEN:0] DEPTH_W    = {1'b1, {LGFLEN{1'b0}}};
    localparam logic [LGFLEN:0] ONE_W      = {{LGFLEN{1'b0}}, 1'b1};
    localparam logic [DW-1:0]   TERM_A_W   = DW'(TERM_A);
    localparam logic [DW-1:0]   TERM_B_W   = DW'(TERM_B);
    localparam logic [TOW-1:0]  TIMEOUT_W  = TOW'(TIMEOUT);
    localparam logic [TOW-1:0]  CNT_ONE_W  = {{(TOW-1){1'b0}}, 1'b1};
    localparam bit              TIMEOUT_EN = (TIMEOUT != 32'd0);

    logic [DW-1:0]   mem_r [0:DEPTH-1];
    logic [LGFLEN:0] head_r, tail_r, commit_r, fill_r;
    logic [TOW-1:0]  cnt_r;
    logic            tx_stb_r, empty_r, full_r, overflow_r;
    logic [DW-1:0]   tx_data_r;

    logic            full_s, wr_s, drop_s, term_s, acc_s;
    logic [LGFLEN:0] head_nxt_s, tail_nxt_s, commit_nxt_s, pend_s, fill_nxt_s;
    logic [31:0]     pend_ext_s;
    logic [TOW-1:0]  cnt_nxt_s;

    // Write/accept qualification and next-pointer arithmetic
    always_comb begin
        full_s     = ((head_r - tail_r) == DEPTH_W);
        wr_s       = i_rx_stb && !full_s;
        drop_s     = i_rx_stb && full_s;
        term_s     = (i_rx_data == TERM_A_W) || (i_rx_data == TERM_B_W);
        acc_s      = tx_stb_r && !i_tx_busy;
        head_nxt_s = wr_s  ? (head_r + ONE_W) : head_r;
        tail_nxt_s = acc_s ? (tail_r + ONE_W) : tail_r;
        pend_s     = head_r - commit_r;
        pend_ext_s = {{(31-LGFLEN){1'b0}}, pend_s};
        fill_nxt_s = head_nxt_s - tail_nxt_s;
    end

    // Commit pointer selection, highest priority first
    always_comb begin
        commit_nxt_s = commit_r;
        if (!i_line_mode) begin
            commit_nxt_s = head_nxt_s;
        end else if (wr_s && term_s) begin
            commit_nxt_s = head_r + ONE_W;
        end else if (drop_s && term_s) begin
            commit_nxt_s = head_r;
        end else if (pend_ext_s >= MAXLINE) begin
            commit_nxt_s = head_r;
        end else if (TIMEOUT_EN && (cnt_r == TIMEOUT_W) && (head_r != commit_r)) begin
            commit_nxt_s = head_r;
        end else begin
            commit_nxt_s = commit_r;
        end
    end

    // Idle counter: restarts on any activity, saturates at the timeout
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (i_rx_stb || (commit_nxt_s != commit_r) || (head_r == commit_r)) begin
            cnt_nxt_s = {TOW{1'b0}};
        end else if (cnt_r < TIMEOUT_W) begin
            cnt_nxt_s = cnt_r + CNT_ONE_W;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Storage array; contents need no reset since pointers gate every read
    always_ff @(posedge i_clk) begin
        if (wr_s) begin
            mem_r[head_r[LGFLEN-1:0]] <= i_rx_data;
        end
    end

    // Pointers, status and sticky overflow
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_r     <= {(LGFLEN+1){1'b0}};
            tail_r     <= {(LGFLEN+1){1'b0}};
            commit_r   <= {(LGFLEN+1){1'b0}};
            cnt_r      <= {TOW{1'b0}};
            fill_r     <= {(LGFLEN+1){1'b0}};
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            commit_r   <= commit_nxt_s;
            cnt_r      <= cnt_nxt_s;
            fill_r     <= fill_nxt_s;
            empty_r    <= (fill_nxt_s == {(LGFLEN+1){1'b0}});
            full_r     <= (fill_nxt_s == DEPTH_W);
            overflow_r <= overflow_r || drop_s;
        end
    end

    // Transmit handshake: one idle cycle after each accept limits rate to 1/2
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_stb_r <= 1'b0;
        end else if (tx_stb_r) begin
            if (!i_tx_busy) begin
                tx_stb_r <= 1'b0;
            end else begin
                tx_stb_r <= 1'b1;
            end
        end else if (tail_r != commit_r) begin
            tx_stb_r  <= 1'b1;
            tx_data_r <= mem_r[tail_r[LGFLEN-1:0]];
        end else begin
            tx_stb_r <= 1'b0;
        end
    end

    assign o_tx_stb   = tx_stb_r;
    assign o_tx_data  = tx_data_r;
    assign o_fill     = fill_r;
    assign o_empty    = empty_r;
    assign o_full     = full_r;
    assign o_overflow = overflow_r;

endmodule

// File: tb/tb_line_fifo.sv
// Directed bench for line_fifo: three instances (plain, short line, timeout)
// share one stimulus; each step checks only the instance it targets.
module tb_line_fifo;

    logic       s_clk = 1'b0;
    logic       reset = 1'b0;
    logic       line_mode = 1'b1;
    logic       rx_stb = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_busy = 1'b0;

    logic       a_tx_stb, b_tx_stb, c_tx_stb;
    logic [7:0] a_tx_data, b_tx_data, c_tx_data;
    logic [4:0] a_fill, b_fill, c_fill;
    logic       a_empty, b_empty, c_empty;
    logic       a_full, b_full, c_full;
    logic       a_overflow, b_overflow, c_overflow;

    int total = 0;
    int bad = 0;
    logic [7:0] got_q[$];

    always #5 s_clk = ~s_clk;

    line_fifo #(.DW(8), .LGFLEN(4), .MAXLINE(80), .TIMEOUT(0)) u_a (
        .i_clk(s_clk), .i_reset(reset), .i_line_mode(line_mode),
        .i_rx_stb(rx_stb), .i_rx_data(rx_data),
        .o_tx_stb(a_tx_stb), .o_tx_data(a_tx_data), .i_tx_busy(tx_busy),
        .o_fill(a_fill), .o_empty(a_empty), .o_full(a_full), .o_overflow(a_overflow));

    line_fifo #(.DW(8), .LGFLEN(4), .MAXLINE(4), .TIMEOUT(0)) u_b (
        .i_clk(s_clk), .i_reset(reset), .i_line_mode(line_mode),
        .i_rx_stb(rx_stb), .i_rx_data(rx_data),
        .o_tx_stb(b_tx_stb), .o_tx_data(b_tx_data), .i_tx_busy(tx_busy),
        .o_fill(b_fill), .o_empty(b_empty), .o_full(b_full), .o_overflow(b_overflow));

    line_fifo #(.DW(8), .LGFLEN(4), .MAXLINE(80), .TIMEOUT(10)) u_c (
        .i_clk(s_clk), .i_reset(reset), .i_line_mode(line_mode),
        .i_rx_stb(rx_stb), .i_rx_data(rx_data),
        .o_tx_stb(c_tx_stb), .o_tx_data(c_tx_data), .i_tx_busy(tx_busy),
        .o_fill(c_fill), .o_empty(c_empty), .o_full(c_full), .o_overflow(c_overflow));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        rx_stb = 1'b0;
        tick();
        reset  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_stb  = 1'b1;
        rx_data = b;
        tick();
        rx_stb  = 1'b0;
    endtask

    // Record every word the selected instance hands over (stb high, not busy)
    task automatic drain(input int sel, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            case (sel)
                0: if (a_tx_stb && !tx_busy) got_q.push_back(a_tx_data);
                1: if (b_tx_stb && !tx_busy) got_q.push_back(b_tx_data);
                default: if (c_tx_stb && !tx_busy) got_q.push_back(c_tx_data);
            endcase
            tick();
        end
    endtask

    logic [7:0] t1_exp [0:2];
    int n;
    logic seen;

    initial begin
        t1_exp[0] = 8'h41; t1_exp[1] = 8'h42; t1_exp[2] = 8'h0a;

        // Reset state of all three instances
        do_reset();
        check("rst_stb",   {a_tx_stb, b_tx_stb, c_tx_stb}, 3'b000);
        check("rst_fill",  {a_fill, b_fill, c_fill}, 15'd0);
        check("rst_empty", {a_empty, b_empty, c_empty}, 3'b111);
        check("rst_full",  {a_full, b_full, c_full}, 3'b000);
        check("rst_ovf",   {a_overflow, b_overflow, c_overflow}, 3'b000);

        // Line mode: "AB\n" held until the terminator, then drained at 1/2 rate
        line_mode = 1'b1; tx_busy = 1'b0;
        send(8'h41); check("t1_hold41", a_tx_stb, 1'b0);
        send(8'h42); check("t1_hold42", a_tx_stb, 1'b0);
        check("t1_fill2", a_fill, 5'd2);
        send(8'h0a); check("t1_fill3", a_fill, 5'd3);
        check("t1_stb_term_edge", a_tx_stb, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_stb_hi", a_tx_stb, 1'b1);
            check("t1_data", a_tx_data, t1_exp[i]);
            tick();
            check("t1_stb_gap", a_tx_stb, 1'b0);
        end
        check("t1_empty", a_empty, 1'b1);
        check("t1_fill0", a_fill, 5'd0);

        // Length commit with MAXLINE=4: 30..33 go out, 34,35 stay
        do_reset();
        for (int i = 0; i < 6; i++) send(8'h30 + 8'(i));
        got_q.delete();
        drain(1, 20);
        check("t2_count", got_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check("t2_data", got_q[i], 8'h30 + 8'(i));
        end
        check("t2_fill2", b_fill, 5'd2);
        check("t2_no_stb", b_tx_stb, 1'b0);

        // Full and overflow: 16 stored, CR as word 17 dropped but commits all
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) send(8'h50 + 8'(i));
        check("t3_full", a_full, 1'b1);
        check("t3_fill16", a_fill, 5'd16);
        check("t3_uncommitted", a_tx_stb, 1'b0);
        send(8'h0d);
        check("t3_ovf", a_overflow, 1'b1);
        check("t3_fill_keep", a_fill, 5'd16);
        tick();
        check("t3_stb_busy", a_tx_stb, 1'b1);
        check("t3_first", a_tx_data, 8'h50);
        tx_busy = 1'b0;
        got_q.delete();
        drain(0, 40);
        check("t3_count", got_q.size(), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < got_q.size()) check("t3_data", got_q[i], 8'h50 + 8'(i));
        end
        check("t3_empty", a_empty, 1'b1);
        check("t3_ovf_sticky", a_overflow, 1'b1);

        // Timeout=10: stb rises 12 edges after the rx edge
        do_reset();
        send(8'h55);
        n = 0;
        while (!c_tx_stb && n < 20) begin tick(); n++; end
        check("t4_latency", n, 32'd12);
        check("t4_data", c_tx_data, 8'h55);
        tick(); tick();
        check("t4_empty", c_empty, 1'b1);

        // Second rx at clock 9 restarts the idle count
        do_reset();
        send(8'h55);
        repeat (8) tick();
        check("t4_no_early", c_tx_stb, 1'b0);
        send(8'h56);
        n = 0;
        while (!c_tx_stb && n < 20) begin tick(); n++; end
        check("t4_restart_latency", n, 32'd12);
        got_q.delete();
        drain(2, 6);
        check("t4_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            check("t4_w0", got_q[0], 8'h55);
            check("t4_w1", got_q[1], 8'h56);
        end

        // Pass-through with the transmitter busy for 5 cycles
        do_reset();
        line_mode = 1'b0; tx_busy = 1'b1;
        send(8'h61);
        check("t5_stb_lat", a_tx_stb, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_stb_hold", a_tx_stb, 1'b1);
            check("t5_data_hold", a_tx_data, 8'h61);
            tick();
        end
        tx_busy = 1'b0;
        check("t5_stb_free", a_tx_stb, 1'b1);
        tick();
        check("t5_accepted", a_tx_stb, 1'b0);
        check("t5_empty", a_empty, 1'b1);

        // Reset mid-drain discards pending words
        line_mode = 1'b1; tx_busy = 1'b1;
        send(8'h41); send(8'h42); send(8'h0a);
        tick();
        check("t6_stb_pre", a_tx_stb, 1'b1);
        check("t6_fill_pre", a_fill, 5'd3);
        tx_busy = 1'b0;
        do_reset();
        check("t6_stb", a_tx_stb, 1'b0);
        check("t6_fill", a_fill, 5'd0);
        check("t6_ovf", a_overflow, 1'b0);
        check("t6_empty", a_empty, 1'b1);
        seen = 1'b0;
        repeat (10) begin tick(); seen = seen | a_tx_stb; end
        check("t6_no_tx", seen, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
